// File: rtl/ifetch_stage.sv
// ifetch_stage: instruction fetch stage sitting after the PC register.
// Issues one instruction-memory request at a time, buffers the returned
// instruction for decode and squashes fetches made stale by a redirect.
// Optional feature macro: IFETCH_PERF_EN adds saturating fetch/stall counters
// (perf_fetch_cnt, perf_stall_cnt); without it those ports do not exist.

module ifetch_stage #(
   parameter logic [31:0] PC_INC    = 32'd4,
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_curr,
   output logic [31:0] pc_next,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_stall_cnt
`endif
);

   typedef enum logic [1:0] {
      REQ  = 2'd0,
      WAIT = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        kill_q, kill_d;
   logic [31:0] reqPc_q, reqPc_d;
   logic        ifValid_q, ifValid_d;
   logic [31:0] ifInstr_q, ifInstr_d;
   logic [31:0] ifPc_q, ifPc_d;
   logic        reqValid;
   logic        reqAccept;

   // Next-state logic: one request in flight, kill marks a fetch made stale by a redirect.
   always_comb begin
      state_d   = state_q;
      kill_d    = kill_q;
      reqPc_d   = reqPc_q;
      ifValid_d = ifValid_q;
      ifInstr_d = ifInstr_q;
      ifPc_d    = ifPc_q;
      reqValid  = 1'b0;
      reqAccept = 1'b0;
      case (state_q)
         REQ: begin
            reqValid = !rst;
            if (imem_req_ready && !rst) begin
               reqAccept = 1'b1;
               reqPc_d   = pc_curr;
               kill_d    = redirect_valid;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            if (imem_resp_valid) begin
               kill_d = 1'b0;
               if (kill_q || redirect_valid) begin
                  state_d = REQ;
               end else begin
                  ifInstr_d = imem_resp_data;
                  ifPc_d    = reqPc_q;
                  ifValid_d = 1'b1;
                  state_d   = HOLD;
               end
            end else if (redirect_valid) begin
               kill_d = 1'b1;
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               ifValid_d = 1'b0;
               ifInstr_d = NOP_INSTR;
               state_d   = REQ;
            end else if (if_ready) begin
               ifValid_d = 1'b0;
               state_d   = REQ;
            end
         end
         default: begin
            state_d = REQ;
         end
      endcase
   end

   // Next PC selection: redirect beats sequential advance, which beats holding.
   always_comb begin
      pc_next = pc_curr;
      if (!rst) begin
         if (redirect_valid) begin
            pc_next = redirect_target & ~32'h3;
         end else if (reqAccept) begin
            pc_next = pc_curr + PC_INC;
         end
      end
   end

   // State and output-buffer registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= REQ;
         kill_q    <= 1'b0;
         reqPc_q   <= 32'd0;
         ifValid_q <= 1'b0;
         ifInstr_q <= NOP_INSTR;
         ifPc_q    <= 32'd0;
      end else begin
         state_q   <= state_d;
         kill_q    <= kill_d;
         reqPc_q   <= reqPc_d;
         ifValid_q <= ifValid_d;
         ifInstr_q <= ifInstr_d;
         ifPc_q    <= ifPc_d;
      end
   end

   assign imem_req_valid = reqValid;
   assign imem_req_addr  = pc_curr;
   assign if_valid       = ifValid_q;
   assign if_instr       = ifInstr_q;
   assign if_pc          = ifPc_q;

`ifdef IFETCH_PERF_EN
   logic [31:0] perfFetch_q;
   logic [31:0] perfStall_q;

   // Saturating counters for delivered instructions and cycles spent waiting on memory.
   always_ff @(posedge clk) begin
      if (rst) begin
         perfFetch_q <= 32'd0;
         perfStall_q <= 32'd0;
      end else begin
         if (ifValid_q && if_ready && !redirect_valid && (perfFetch_q != 32'hFFFFFFFF)) begin
            perfFetch_q <= perfFetch_q + 32'd1;
         end
         if ((((state_q == REQ) && !imem_req_ready) || (state_q == WAIT)) &&
             (perfStall_q != 32'hFFFFFFFF)) begin
            perfStall_q <= perfStall_q + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = perfFetch_q;
   assign perf_stall_cnt = perfStall_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: the bench plays the PC register and
// the instruction memory, keeps a small reference model of the fetch state and
// a scoreboard of instructions that decode should see.

module tb_ifetch_stage;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk;
   logic        rst;
   logic [31:0] pc_curr;
   logic [31:0] pc_next;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   ifetch_stage dut (
      .clk             (clk),
      .rst             (rst),
      .pc_curr         (pc_curr),
      .pc_next         (pc_next),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {M_REQ, M_WAIT, M_HOLD} mState_t;
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t      sbQueue[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          delivered  = 0;
   logic [31:0] pcReg;
   mState_t     expState;
   logic        expKill;
   logic [31:0] expReqAddr;
   logic        memPend;
   logic [31:0] memAddr;
   int          memCnt;
   int          respDelay;
   logic        injectResp;

   // Instruction memory contents as a function of address.
   function automatic logic [31:0] memFn(input logic [31:0] a);
      if (a == 32'h20) return 32'hDEADBEEF;
      return (a * 32'd3) + 32'h10000013;
   endfunction

   // Compare one observed value with the expected one and log a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
      end
   endtask

   // Drive one clock cycle, check outputs against the model, then advance model and memory.
   task automatic applyStimulus(input logic rstV, input logic readyV, input logic ifReadyV,
                                input logic redirV, input logic [31:0] target);
      logic        reqV;
      logic        accept;
      logic        dutAccept;
      logic        respNow;
      logic [31:0] dutAddr;
      logic [31:0] expNext;
      logic [31:0] sampledNext;
      entry_t      e;
      rst             = rstV;
      imem_req_ready  = readyV;
      if_ready        = ifReadyV;
      redirect_valid  = redirV;
      redirect_target = target;
      pc_curr         = pcReg;
      #1;
      reqV = (expState == M_REQ) && !rstV;
      checkOutput("req_valid", {31'b0, imem_req_valid}, {31'b0, reqV});
      if (reqV) checkOutput("req_addr", imem_req_addr, pcReg);
      accept = reqV && readyV;
      if (rstV)        expNext = pcReg;
      else if (redirV) expNext = {target[31:2], 2'b00};
      else if (accept) expNext = pcReg + 32'd4;
      else             expNext = pcReg;
      checkOutput("pc_next", pc_next, expNext);
      sampledNext = pc_next;
      dutAccept   = imem_req_valid && readyV;
      dutAddr     = imem_req_addr;
      respNow     = imem_resp_valid;
      if (!rstV) begin
         if (expState == M_HOLD) begin
            checkOutput("if_valid", {31'b0, if_valid}, 32'd1);
            if (sbQueue.size() > 0) begin
               checkOutput("if_instr", if_instr, sbQueue[0].instr);
               checkOutput("if_pc", if_pc, sbQueue[0].pc);
            end
         end else begin
            checkOutput("if_valid", {31'b0, if_valid}, 32'd0);
         end
      end
      if (rstV) begin
         expState = M_REQ;
         expKill  = 1'b0;
      end else begin
         case (expState)
            M_REQ: begin
               if (accept) begin
                  expState   = M_WAIT;
                  expKill    = redirV;
                  expReqAddr = pcReg;
               end
            end
            M_WAIT: begin
               if (respNow) begin
                  if (!(expKill || redirV)) begin
                     e.pc    = expReqAddr;
                     e.instr = memFn(expReqAddr);
                     sbQueue.push_back(e);
                     expState = M_HOLD;
                  end else begin
                     expState = M_REQ;
                  end
                  expKill = 1'b0;
               end else if (redirV) begin
                  expKill = 1'b1;
               end
            end
            default: begin
               if (redirV) begin
                  if (sbQueue.size() > 0) void'(sbQueue.pop_front());
                  expState = M_REQ;
               end else if (ifReadyV) begin
                  if (sbQueue.size() > 0) void'(sbQueue.pop_front());
                  delivered++;
                  expState = M_REQ;
               end
            end
         endcase
      end
      @(posedge clk);
      if (rstV) begin
         memPend = 1'b0;
      end else begin
         if (respNow) memPend = 1'b0;
         if (dutAccept) begin
            memPend = 1'b1;
            memAddr = dutAddr;
            memCnt  = respDelay;
         end
      end
      pcReg = rstV ? 32'd0 : sampledNext;
      @(negedge clk);
      if (injectResp) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hBAD0BAD0;
         injectResp      = 1'b0;
      end else if (memPend && (memCnt == 0)) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memFn(memAddr);
      end else begin
         imem_resp_valid = 1'b0;
         if (memPend) memCnt--;
      end
   endtask

   // Run several plain cycles with fixed handshake inputs.
   task automatic runCycles(input int n, input logic readyV, input logic ifReadyV);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, readyV, ifReadyV, 1'b0, 32'd0);
   endtask

   // Hard stop if the sequence ever stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      rst             = 1'b1;
      pc_curr         = 32'd0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'd0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      if_ready        = 1'b0;
      pcReg           = 32'd0;
      expState        = M_REQ;
      expKill         = 1'b0;
      expReqAddr      = 32'd0;
      memPend         = 1'b0;
      memAddr         = 32'd0;
      memCnt          = 0;
      respDelay       = 0;
      injectResp      = 1'b0;
      @(negedge clk);

      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h44);
      checkOutput("rst_if_valid", {31'b0, if_valid}, 32'd0);
      checkOutput("rst_if_instr", if_instr, NOP);
      checkOutput("rst_if_pc", if_pc, 32'd0);

      runCycles(9, 1'b1, 1'b1);
      checkOutput("seq_delivered", delivered, 32'd3);
      checkOutput("seq_pc", pcReg, 32'hC);

      runCycles(3, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
         checkOutput("stall_addr", imem_req_addr, 32'h10);
         checkOutput("stall_pc", pcReg, 32'h10);
      end
      checkOutput("stall_delivered", delivered, 32'd4);

      runCycles(12, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
         checkOutput("hold_valid", {31'b0, if_valid}, 32'd1);
         checkOutput("hold_instr", if_instr, 32'hDEADBEEF);
         checkOutput("hold_pc", if_pc, 32'h20);
         checkOutput("hold_no_req", {31'b0, imem_req_valid}, 32'd0);
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("hold_delivered", delivered, 32'd9);

      respDelay = 2;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
      checkOutput("wait_redir_pc", pcReg, 32'h100);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      respDelay = 0;
      checkOutput("stale_dropped", delivered, 32'd9);
      runCycles(3, 1'b1, 1'b1);
      checkOutput("redir_fetch", delivered, 32'd10);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
      checkOutput("flush_instr", if_instr, NOP);
      checkOutput("flush_valid", {31'b0, if_valid}, 32'd0);
      checkOutput("flush_delivered", delivered, 32'd10);
      runCycles(3, 1'b1, 1'b1);
      checkOutput("flush_refetch", delivered, 32'd11);
      checkOutput("flush_pc", pcReg, 32'h204);

      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF);
      checkOutput("wrap_target", pcReg, 32'hFFFFFFFC);
      respDelay = 5;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("wrap_pc", pcReg, 32'd0);
      injectResp = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h300);
      checkOutput("rst_wait_valid", {31'b0, if_valid}, 32'd0);
      checkOutput("rst_wait_instr", if_instr, NOP);
      respDelay = 0;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
      runCycles(3, 1'b1, 1'b1);
      checkOutput("post_rst_fetch", delivered, 32'd12);
      checkOutput("post_rst_pc", pcReg, 32'd4);

      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h400);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
      checkOutput("req_kill_drop", delivered, 32'd12);
      runCycles(3, 1'b1, 1'b1);
      checkOutput("req_kill_refetch", delivered, 32'd13);
      checkOutput("req_kill_pc", pcReg, 32'h404);
      checkOutput("queue_empty", sbQueue.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
